fft_band_energy: RTL and testbench

- Parametrised successor to the FFT band-energy block.
- Per frame, it walks the FFT magnitude BRAM and accumulates squared magnitude over NUM_BANDS contiguous address bands.
- Each band's energy is converted to a saturating LEVEL_W-bit level through a per-band right shift, then passed through optional peak-hold/decay.
- It sits between the FFT magnitude BRAM and the colour/LED mapping logic, which consumes the packed levels.

---
 rtl/fft_band_pkg.sv | 25 ++
 rtl/fft_band_energy_hold.sv | 43 ++++
 rtl/fft_band_energy.sv | 144 ++++++++++++++
 tb/tb_fft_band_energy.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_band_pkg.sv
// Shared types and helpers for the FFT band-energy block: FSM encoding,
// saturating level conversion and packed-bus slice indexing.
package fft_band_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_UPDATE,
    S_DONE
  } state_t;

  // Clamp an already-shifted energy to an lw-bit level (all-ones on overflow).
  function automatic logic [31:0] sat_level(input logic [63:0] raw, input int unsigned lw);
    logic [63:0] lim;
    lim = 64'd1 << lw;
    if (raw >= lim) return 32'(lim - 64'd1);
    return raw[31:0];
  endfunction

  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/fft_band_energy_hold.sv
// Per-band level register: shift/saturate the band energy, then apply
// freeze, peak-hold and optional one-step decay when this band updates.
module band_level_hold
  import fft_band_pkg::*;
#(
  parameter int unsigned ACC_W   = 42,
  parameter int unsigned SHIFT_W = 6,
  parameter int unsigned LEVEL_W = 4
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               upd_i,
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               freeze_i,
  input  logic               decay_en_i,
  output logic [LEVEL_W-1:0] level_o
);

  logic [ACC_W-1:0]   raw;
  logic [LEVEL_W-1:0] lvl, level_q, level_d, dec_lvl;

  assign raw     = acc_i >> shift_i;
  assign lvl     = LEVEL_W'(sat_level(64'(raw), LEVEL_W));
  assign dec_lvl = level_q - LEVEL_W'(1);

  always_comb begin
    level_d = level_q;
    if (upd_i && !freeze_i) begin
      if (lvl >= level_q)  level_d = lvl;
      else if (decay_en_i) level_d = (dec_lvl > lvl) ? dec_lvl : lvl;
      else                 level_d = lvl;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) level_q <= '0;
    else            level_q <= level_d;
  end

  assign level_o = level_q;

endmodule

// File: rtl/fft_band_energy.sv
// Walks the FFT magnitude BRAM once per frame, accumulating squared
// magnitude per contiguous address band and updating per-band levels.
module fft_band_energy
  import fft_band_pkg::*;
#(
  parameter int unsigned NUM_BANDS = 7,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned LEVEL_W   = 4,
  parameter int unsigned SHIFT_W   = 6,
  parameter int unsigned ACC_W     = 2*DATA_W+ADDR_W
) (
  input  logic                         clock_i,
  input  logic                         reset_n_i,
  input  logic                         start_i,
  input  logic [ADDR_W-1:0]            base_addr_i,
  input  logic [NUM_BANDS*ADDR_W-1:0]  band_edges_i,
  input  logic [NUM_BANDS*SHIFT_W-1:0] shifts_i,
  input  logic                         freeze_i,
  input  logic                         decay_en_i,
  input  logic [DATA_W-1:0]            data_i,
  output logic [ADDR_W-1:0]            bram_addr_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [NUM_BANDS*LEVEL_W-1:0] levels_o,
  output logic [ACC_W-1:0]             acc_dbg_o
);

  localparam int unsigned BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int unsigned CW = $clog2(RD_LAT + 1);

  state_t                                  state_q, state_d;
  logic [ADDR_W-1:0]                       addr_q, addr_d;
  logic [BW-1:0]                           band_q, band_d, band_nx;
  logic [CW-1:0]                           cnt_q, cnt_d;
  logic [ACC_W-1:0]                        acc_q, acc_d, dbg_q;
  logic [RD_LAT-1:0]                       tag_q;
  logic [NUM_BANDS-1:0][ADDR_W-1:0]        edges_q;
  logic [NUM_BANDS-1:0][SHIFT_W-1:0]       shifts_q;
  logic [2*DATA_W-1:0]                     sq;
  logic [ADDR_W-1:0]                       cur_hi, nxt_hi;
  logic                                    issue, upd, latch, last;

  assign sq      = (2*DATA_W)'(data_i) * (2*DATA_W)'(data_i);
  assign band_nx = band_q + BW'(1);
  assign cur_hi  = edges_q[band_q];
  assign nxt_hi  = edges_q[band_nx];
  assign last    = (band_q == BW'(NUM_BANDS-1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    band_d  = band_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    issue   = 1'b0;
    upd     = 1'b0;
    latch   = 1'b0;
    // A tag at the end of the pipe means data_i belongs to this band now.
    if (tag_q[RD_LAT-1]) acc_d = acc_q + ACC_W'(sq);
    case (state_q)
      S_IDLE: if (start_i) begin
        latch   = 1'b1;
        addr_d  = base_addr_i;
        band_d  = '0;
        acc_d   = '0;
        state_d = (band_edges_i[ADDR_W-1:0] <= base_addr_i) ? S_UPDATE : S_ISSUE;
      end
      S_ISSUE: begin
        issue  = 1'b1;
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == cur_hi - ADDR_W'(1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(RD_LAT-1)) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        upd    = 1'b1;
        acc_d  = '0;
        addr_d = cur_hi;
        band_d = band_nx;
        if (last) state_d = S_DONE;
        else      state_d = (nxt_hi <= cur_hi) ? S_UPDATE : S_ISSUE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      band_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      dbg_q    <= '0;
      tag_q    <= '0;
      edges_q  <= '0;
      shifts_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      band_q   <= band_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      tag_q[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      if (upd) dbg_q <= acc_q;
      if (latch) begin
        edges_q  <= band_edges_i;
        shifts_q <= shifts_i;
      end
    end
  end

  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_band
    band_level_hold #(
      .ACC_W  (ACC_W),
      .SHIFT_W(SHIFT_W),
      .LEVEL_W(LEVEL_W)
    ) u_hold (
      .clock_i   (clock_i),
      .reset_n_i (reset_n_i),
      .upd_i     (upd && (band_q == BW'(g))),
      .acc_i     (acc_q),
      .shift_i   (shifts_q[g]),
      .freeze_i  (freeze_i),
      .decay_en_i(decay_en_i),
      .level_o   (levels_o[slice_lo(g, LEVEL_W) +: LEVEL_W])
    );
  end

  assign bram_addr_o = addr_q;
  assign busy_o      = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_UPDATE);
  assign done_o      = (state_q == S_DONE);
  assign acc_dbg_o   = dbg_q;

endmodule

// File: tb/tb_fft_band_energy.sv
// Scoreboarded bench: a frame-level reference model predicts levels, last
// band energy and frame latency; a negedge monitor checks each done pulse.
module tb_fft_band_energy;

  localparam int NB = 3, AW = 10, DW = 16, RL = 2, LW = 4, SW = 6;
  localparam int AC = 2*DW + AW;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, freeze = 1'b0, decay_en = 1'b0;
  logic [AW-1:0]    base = '0;
  logic [NB*AW-1:0] edges = '0;
  logic [NB*SW-1:0] shifts = '0;
  logic [DW-1:0]    data;
  logic [AW-1:0]    bram_addr;
  logic             busy, done;
  logic [NB*LW-1:0] levels;
  logic [AC-1:0]    acc_dbg;

  logic [DW-1:0] mem [1024];
  logic [AW-1:0] apipe [RL];

  int checks = 0, failures = 0, run_cnt = 0;
  int mlev [NB];

  typedef struct {
    logic [NB*LW-1:0] lv;
    logic [AC-1:0]    dbg;
    int               lat;
  } exp_t;
  exp_t expq [$];

  fft_band_energy #(
    .NUM_BANDS(NB), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL),
    .LEVEL_W(LW), .SHIFT_W(SW), .ACC_W(AC)
  ) dut (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start), .base_addr_i(base),
    .band_edges_i(edges), .shifts_i(shifts), .freeze_i(freeze),
    .decay_en_i(decay_en), .data_i(data), .bram_addr_o(bram_addr),
    .busy_o(busy), .done_o(done), .levels_o(levels), .acc_dbg_o(acc_dbg)
  );

  always #5 clk = ~clk;

  // BRAM model: read data appears RL cycles after the address.
  always @(posedge clk) begin
    apipe[0] <= bram_addr;
    for (int i = 1; i < RL; i++) apipe[i] <= apipe[i-1];
  end
  assign data = mem[apipe[RL-1]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: latency = cycles with busy or done, ending at the done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) run_cnt = 0;
    else begin
      if (busy || done) run_cnt++;
      if (done) begin
        if (expq.size() == 0) check("unexpected_done", 64'(done), 64'd0);
        else begin
          e = expq.pop_front();
          check("levels", 64'(levels), 64'(e.lv));
          check("acc_dbg", 64'(acc_dbg), 64'(e.dbg));
          check("latency", 64'(run_cnt), 64'(e.lat));
        end
        run_cnt = 0;
      end
    end
  end

  task automatic fill(input int mode, input logic [DW-1:0] v);
    for (int a = 0; a < 1024; a++)
      mem[a] = (mode == 0) ? v : (mode == 1) ? DW'($urandom) : DW'($urandom_range(0, 15));
  endtask

  task automatic model_push(input logic [AW-1:0] b, input logic [NB*AW-1:0] ed,
                            input logic [NB*SW-1:0] sh, input bit frz, input bit dec);
    exp_t e;
    logic [63:0] en, raw;
    int lo, hi, lvl;
    e.lat = 1; e.dbg = '0; e.lv = '0;
    lo = int'(b);
    for (int k = 0; k < NB; k++) begin
      hi = int'(ed[k*AW +: AW]);
      en = 0;
      if (hi > lo) begin
        for (int a = lo; a < hi; a++) en += 64'(mem[a]) * 64'(mem[a]);
        e.lat += hi - lo + RL + 1;
      end else e.lat += 1;
      raw = en >> sh[k*SW +: SW];
      lvl = (raw >= 64'(2**LW)) ? (2**LW - 1) : int'(raw);
      if (!frz) begin
        if (lvl >= mlev[k])  mlev[k] = lvl;
        else if (dec)        mlev[k] = (mlev[k] - 1 > lvl) ? mlev[k] - 1 : lvl;
        else                 mlev[k] = lvl;
      end
      e.dbg = AC'(en);
      lo = hi;
    end
    for (int k = 0; k < NB; k++) e.lv[k*LW +: LW] = LW'(mlev[k]);
    expq.push_back(e);
  endtask

  task automatic drive_start(input logic [AW-1:0] b, input logic [NB*AW-1:0] ed,
                             input logic [NB*SW-1:0] sh, input bit frz, input bit dec);
    @(negedge clk);
    base = b; edges = ed; shifts = sh; freeze = frz; decay_en = dec; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic frame(input logic [AW-1:0] b, input logic [NB*AW-1:0] ed,
                       input logic [NB*SW-1:0] sh, input bit frz, input bit dec, input bit extra);
    int n;
    model_push(b, ed, sh, frz, dec);
    drive_start(b, ed, sh, frz, dec);
    if (extra) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 64'(done), 64'd1);
    @(negedge clk);
  endtask

  localparam logic [NB*AW-1:0] ED_STD = {10'd8, 10'd8, 10'd4};
  localparam logic [NB*SW-1:0] SH_2   = {6'd2, 6'd2, 6'd2};

  initial begin
    logic [NB*AW-1:0] ed;
    logic [NB*SW-1:0] sh;
    int prev, e;
    logic [AW-1:0] b;
    for (int k = 0; k < NB; k++) mlev[k] = 0;
    fill(0, 16'd3);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_levels", 64'(levels), 64'd0);
    check("rst_addr", 64'(bram_addr), 64'd0);
    check("rst_acc_dbg", 64'(acc_dbg), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    frame(10'd0, ED_STD, SH_2, 1'b0, 1'b0, 1'b0);            // 9,9,0 latency 16
    fill(0, 16'hFFFF);
    frame(10'd0, ED_STD, '0, 1'b0, 1'b0, 1'b0);               // saturation
    fill(0, 16'd3);
    frame(10'd0, ED_STD, SH_2, 1'b0, 1'b0, 1'b0);             // back to 9
    fill(0, 16'd0);
    frame(10'd0, ED_STD, SH_2, 1'b0, 1'b1, 1'b0);             // decay to 8
    frame(10'd0, ED_STD, SH_2, 1'b0, 1'b0, 1'b0);             // drop to 0
    fill(0, 16'd3);
    frame(10'd0, ED_STD, SH_2, 1'b0, 1'b0, 1'b0);
    fill(0, 16'hFFFF);
    frame(10'd0, ED_STD, SH_2, 1'b1, 1'b0, 1'b0);             // frozen at 9
    fill(0, 16'd3);
    frame(10'd0, ED_STD, SH_2, 1'b0, 1'b0, 1'b1);             // extra start ignored
    repeat (3) @(negedge clk);
    check("idle_after_extra_start", 64'(busy), 64'd0);

    // Asynchronous reset while walking band 1.
    drive_start(10'd0, ED_STD, SH_2, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_levels", 64'(levels), 64'd0);
    check("midrst_addr", 64'(bram_addr), 64'd0);
    for (int k = 0; k < NB; k++) mlev[k] = 0;
    expq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_resume_after_rst", 64'(busy), 64'd0);
    frame(10'd0, ED_STD, SH_2, 1'b0, 1'b0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      fill(($urandom_range(0, 2) == 0) ? 2 : 1, '0);
      b = AW'($urandom_range(0, 900));
      prev = int'(b);
      for (int k = 0; k < NB; k++) begin
        if ($urandom_range(0, 5) == 0) e = $urandom_range(0, prev);
        else                           e = prev + $urandom_range(1, 12);
        ed[k*AW +: AW] = AW'(e);
        sh[k*SW +: SW] = ($urandom_range(0, 7) == 0) ? SW'(63) :
                         ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 6)) :
                                                       SW'($urandom_range(26, 36));
        prev = e;
      end
      frame(b, ed, sh, ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1), 1'b0);
    end

    check("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
